// File: rtl/pq_cmd_buffer_if.sv
// Command/response handshake bundle between a producer and pq_cmd_buffer.
interface pq_cmd_buffer_if #(
    parameter int KW = 8,
    parameter int VW = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [KW+VW-1:0]  cmd_kv;
    logic              rsp_valid;
    logic [KW+VW-1:0]  rsp_kv;
    logic              rsp_ready;

    modport master (
        output cmd_valid, cmd_op, cmd_kv, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_kv
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_kv, rsp_ready,
        output cmd_ready, rsp_valid, rsp_kv
    );
endinterface

// File: rtl/pq_cmd_buffer.sv
// Command FIFO feeding a priority queue one command at a time, with response capture.
// Optional macro PQ_CMD_DROP_EN: illegal head commands are discarded and counted in drop_cnt.
module pq_cmd_buffer #(
    parameter int DEPTH = 4,
    parameter int KW    = 8,
    parameter int VW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    pq_cmd_buffer_if.slave     bus,
    output logic               pq_enq,
    output logic               pq_deq,
    output logic [KW+VW-1:0]   pq_kvi,
    input  logic [KW+VW-1:0]   pq_kvo,
    input  logic               pq_full,
    input  logic               pq_empty,
    input  logic               pq_busy,
    output logic [7:0]         drop_cnt
);
    localparam int W  = KW + VW;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ENQ = 2'b01,
        OP_DEQ = 2'b10,
        OP_REP = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    op_t          op_mem [DEPTH];
    logic [W-1:0] kv_mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr, wr_next, rd_next;
    logic         fifo_empty, full_next;
    logic         push, pop, issue, head_legal;
    logic         cmd_ready_q, rsp_valid_q;
    logic [W-1:0] rsp_kv_q;
    op_t          head_op, cur_op;
    logic [W-1:0] head_kv;
    state_t       state;
`ifdef PQ_CMD_DROP_EN
    logic         drop;
`endif

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_kv    = rsp_kv_q;

    assign push       = bus.cmd_valid && cmd_ready_q;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign head_op    = op_mem[rd_ptr[AW-1:0]];
    assign head_kv    = kv_mem[rd_ptr[AW-1:0]];
    assign wr_next    = wr_ptr + (AW+1)'(push);
    assign rd_next    = rd_ptr + (AW+1)'(pop);
    assign full_next  = (wr_next[AW] != rd_next[AW]) &&
                        (wr_next[AW-1:0] == rd_next[AW-1:0]);

    always_comb begin
        head_legal = 1'b1;
        case (head_op)
            OP_ENQ:         head_legal = !pq_full;
            OP_DEQ, OP_REP: head_legal = !pq_empty;
            default:        head_legal = 1'b1;
        endcase
    end

    // Nops retire without touching the queue, so they ignore pq_busy.
    always_comb begin
        pop   = 1'b0;
        issue = 1'b0;
`ifdef PQ_CMD_DROP_EN
        drop  = 1'b0;
`endif
        if (state == IDLE && !fifo_empty) begin
            if (head_op == OP_NOP) begin
                pop = 1'b1;
            end else if (head_legal) begin
                if (!pq_busy) begin
                    pop   = 1'b1;
                    issue = 1'b1;
                end
            end
`ifdef PQ_CMD_DROP_EN
            else begin
                pop  = 1'b1;
                drop = 1'b1;
            end
`endif
        end
    end

    // cmd_ready follows the post-edge fill level so a full FIFO never overfills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            wr_ptr      <= wr_next;
            rd_ptr      <= rd_next;
            cmd_ready_q <= !full_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr[AW-1:0]] <= op_t'(bus.cmd_op);
            kv_mem[wr_ptr[AW-1:0]] <= bus.cmd_kv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cur_op      <= OP_NOP;
            pq_enq      <= 1'b0;
            pq_deq      <= 1'b0;
            pq_kvi      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_kv_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state  <= ISSUE;
                        cur_op <= head_op;
                        pq_enq <= (head_op == OP_ENQ) || (head_op == OP_REP);
                        pq_deq <= (head_op == OP_DEQ) || (head_op == OP_REP);
                        pq_kvi <= (head_op == OP_DEQ) ? '0 : head_kv;
                    end
                end
                ISSUE: begin
                    state  <= WAIT;
                    pq_enq <= 1'b0;
                    pq_deq <= 1'b0;
                    pq_kvi <= '0;
                end
                WAIT: begin
                    if (!pq_busy) begin
                        if (cur_op == OP_ENQ) begin
                            state <= IDLE;
                        end else begin
                            state       <= RESP;
                            rsp_kv_q    <= pq_kvo;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PQ_CMD_DROP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pq_cmd_buffer.sv
// Directed scenarios plus randomized traffic against a queue-level reference of pq_cmd_buffer.
module tb_pq_cmd_buffer;
    localparam int KW     = 8;
    localparam int VW     = 8;
    localparam int W      = KW + VW;
    localparam int DEPTH  = 4;
    localparam int PQ_CAP = 6;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] ENQ = 2'b01;
    localparam logic [1:0] DEQ = 2'b10;
    localparam logic [1:0] REP = 2'b11;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] kv;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         pq_enq, pq_deq;
    logic [W-1:0] pq_kvi, pq_kvo;
    logic         pq_full, pq_empty, pq_busy;
    logic [7:0]   drop_cnt;

    always #5 clk = ~clk;

    pq_cmd_buffer_if #(.KW(KW), .VW(VW)) bus ();

    pq_cmd_buffer #(.DEPTH(DEPTH), .KW(KW), .VW(VW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .pq_enq   (pq_enq),
        .pq_deq   (pq_deq),
        .pq_kvi   (pq_kvi),
        .pq_kvo   (pq_kvo),
        .pq_full  (pq_full),
        .pq_empty (pq_empty),
        .pq_busy  (pq_busy),
        .drop_cnt (drop_cnt)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic send(input logic [1:0] op, input logic [W-1:0] kv);
        bit ok;
        ok = 1'b0;
        bus.cmd_op    = op;
        bus.cmd_kv    = kv;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.cmd_ready) ok = 1'b1;
            else tick();
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Random-phase reference state.
    ent_t         exp_issue[$];
    logic [W-1:0] exp_rsp[$];
    int           gen_cnt, fake_cnt, busy_cnt, n_issued;
    logic [W-1:0] fin_kvo;
    bit           acc_pending, prev_strobe, held, gen_on;
    logic [W-1:0] held_kv;

    task automatic gen_cmd();
        logic [1:0] op;
        if (gen_on && $urandom_range(0, 3) != 0) begin
            op = 2'($urandom_range(0, 3));
            if (op == ENQ && gen_cnt >= PQ_CAP) op = DEQ;
            if ((op == DEQ || op == REP) && gen_cnt == 0) op = ENQ;
            if (op == ENQ) gen_cnt++;
            if (op == DEQ) gen_cnt--;
            bus.cmd_op    = op;
            bus.cmd_kv    = W'($urandom);
            bus.cmd_valid = 1'b1;
        end else begin
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic rand_cycle();
        ent_t e;
        logic [1:0] want;
        tick();
        if (pq_enq || pq_deq) begin
            check("strobe_one_cycle", 32'(prev_strobe), 32'd0);
            check("one_outstanding", 32'((busy_cnt != 0) || (exp_rsp.size() != 0)), 32'd0);
            n_issued++;
            if (exp_issue.size() == 0) begin
                check("issue_extra", 32'd1, 32'd0);
            end else begin
                e = exp_issue.pop_front();
                want = {e.op == ENQ || e.op == REP, e.op == DEQ || e.op == REP};
                check("issue_op", 32'({pq_enq, pq_deq}), 32'(want));
                check("issue_kvi", 32'(pq_kvi), (e.op == DEQ) ? 32'd0 : 32'(e.kv));
                if (e.op == ENQ) fake_cnt++;
                if (e.op == DEQ) fake_cnt--;
                if (e.op != ENQ) begin
                    fin_kvo = W'($urandom);
                    exp_rsp.push_back(fin_kvo);
                end
            end
            busy_cnt = $urandom_range(0, 3);
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        prev_strobe = pq_enq || pq_deq;
        if (bus.rsp_valid && !held) fin_kvo = W'($urandom);
        pq_busy  = (busy_cnt != 0) || ($urandom_range(0, 7) == 0);
        pq_kvo   = (busy_cnt != 0) ? W'($urandom) : fin_kvo;
        pq_empty = (fake_cnt == 0);
        pq_full  = (fake_cnt == PQ_CAP);

        bus.rsp_ready = 1'($urandom_range(0, 1));
        if (bus.rsp_valid) begin
            if (held) check("rsp_hold", 32'(bus.rsp_kv), 32'(held_kv));
            if (bus.rsp_ready) begin
                if (exp_rsp.size() == 0) check("rsp_extra", 32'd1, 32'd0);
                else check("rsp_kv", 32'(bus.rsp_kv), 32'(exp_rsp.pop_front()));
                held = 1'b0;
            end else begin
                held    = 1'b1;
                held_kv = bus.rsp_kv;
            end
        end else if (held) begin
            check("rsp_valid_hold", 32'd0, 32'd1);
            held = 1'b0;
        end

        if (acc_pending || !bus.cmd_valid) gen_cmd();
        acc_pending = bus.cmd_valid && bus.cmd_ready;
        if (acc_pending && bus.cmd_op != NOP)
            exp_issue.push_back('{op: bus.cmd_op, kv: bus.cmd_kv});
    endtask

    initial begin
        int acc, strobes, enq_seen, rsp_seen;
        bit got5;

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = NOP; bus.cmd_kv = '0; bus.rsp_ready = 1'b0;
        pq_kvo = '0; pq_full = 1'b0; pq_empty = 1'b1; pq_busy = 1'b0;
        tick(); tick();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_strobes", 32'({pq_enq, pq_deq}), 32'd0);
        check("rst_pq_kvi", 32'(pq_kvi), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_kv", 32'(bus.rsp_kv), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        // Enqueue: strobe in the second cycle after acceptance, one cycle wide.
        send(ENQ, 16'h0305);
        check("enq_c1", 32'(pq_enq), 32'd0);
        tick();
        check("enq_strobe", 32'({pq_enq, pq_deq}), 32'b10);
        check("enq_kvi", 32'(pq_kvi), 32'h0305);
        tick();
        check("enq_c3", 32'(pq_enq), 32'd0);
        rsp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid) rsp_seen++;
            tick();
        end
        check("enq_no_rsp", 32'(rsp_seen), 32'd0);

        // Dequeue with response held under back-pressure.
        pq_empty = 1'b0;
        pq_kvo   = 16'h0107;
        send(DEQ, 16'h5555);
        tick();
        check("deq_strobe", 32'({pq_enq, pq_deq}), 32'b01);
        check("deq_kvi", 32'(pq_kvi), 32'd0);
        tick();
        check("deq_wait_rsp", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("deq_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("deq_rsp_kv", 32'(bus.rsp_kv), 32'h0107);
        pq_kvo = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("deq_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("deq_hold_kv", 32'(bus.rsp_kv), 32'h0107);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("deq_rsp_drop", 32'(bus.rsp_valid), 32'd0);
        bus.rsp_ready = 1'b0;

        // Fill the FIFO while the queue is busy.
        pq_busy = 1'b1; pq_empty = 1'b1; pq_full = 1'b0;
        bus.cmd_op = ENQ; bus.cmd_kv = 16'h1000; bus.cmd_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.cmd_ready) acc++;
            tick();
            bus.cmd_kv = W'(16'h1000 + acc);
        end
        check("fill_accepted", 32'(acc), 32'(DEPTH));
        check("fill_ready_low", 32'(bus.cmd_ready), 32'd0);
        pq_busy = 1'b0;
        got5 = 1'b0; enq_seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.cmd_valid && bus.cmd_ready) got5 = 1'b1;
            if (pq_enq) enq_seen++;
            tick();
            if (got5) bus.cmd_valid = 1'b0;
        end
        check("fifth_accepted", 32'(got5), 32'd1);
        check("fill_enq_count", 32'(enq_seen), 32'd5);

        // Dequeue against an empty queue.
        bus.rsp_ready = 1'b1; pq_empty = 1'b1;
        send(DEQ, 16'h0000);
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            if (pq_enq || pq_deq) strobes++;
            tick();
        end
        check("illegal_no_strobe", 32'(strobes), 32'd0);
`ifdef PQ_CMD_DROP_EN
        check("drop_cnt_one", 32'(drop_cnt), 32'd1);
`else
        check("drop_cnt_zero", 32'(drop_cnt), 32'd0);
        pq_empty = 1'b0;
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            if (pq_deq) strobes++;
            tick();
        end
        check("stall_then_deq", 32'(strobes), 32'd1);
`endif

        // Reset while a dequeue waits on a busy queue.
        bus.rsp_ready = 1'b0; pq_empty = 1'b0; pq_busy = 1'b0;
        send(DEQ, 16'h0000);
        tick();
        check("rw_deq_strobe", 32'(pq_deq), 32'd1);
        pq_busy = 1'b1;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("rw_async_ready", 32'(bus.cmd_ready), 32'd0);
        check("rw_async_rsp", 32'(bus.rsp_valid), 32'd0);
        tick();
        rst = 1'b0;
        pq_busy = 1'b0;
        strobes = 0; rsp_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pq_enq || pq_deq) strobes++;
            if (bus.rsp_valid) rsp_seen++;
        end
        check("rw_no_stale_issue", 32'(strobes), 32'd0);
        check("rw_no_rsp", 32'(rsp_seen), 32'd0);
        send(ENQ, 16'h0A0B);
        tick();
        check("rw_enq_strobe", 32'({pq_enq, pq_deq}), 32'b10);
        check("rw_enq_kvi", 32'(pq_kvi), 32'h0A0B);

        // Randomized traffic.
        do_reset();
        exp_issue.delete(); exp_rsp.delete();
        gen_cnt = 0; fake_cnt = 0; busy_cnt = 0; n_issued = 0;
        fin_kvo = '0; acc_pending = 1'b0; prev_strobe = 1'b0; held = 1'b0;
        pq_empty = 1'b1; pq_full = 1'b0; pq_busy = 1'b0;
        gen_on = 1'b1;
        for (int i = 0; i < 3000; i++) rand_cycle();
        gen_on = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (exp_issue.size() == 0 && exp_rsp.size() == 0 && !bus.cmd_valid && !acc_pending) break;
            rand_cycle();
        end
        for (int i = 0; i < 10; i++) rand_cycle();
        check("drain_issue", 32'(exp_issue.size()), 32'd0);
        check("drain_rsp", 32'(exp_rsp.size()), 32'd0);
        check("rand_activity", 32'(n_issued > 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
